// File: rtl/ifu_fetch_ctrl_if.sv
// Read-only AR/R bus between the fetch stage and instruction memory.
// master: fetch stage (drives AR, accepts R); slave: memory.
interface ifu_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             mem_arvalid;
    logic [WIDTH-1:0] mem_araddr;
    logic             mem_arready;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic [1:0]       mem_rresp;
    logic             mem_rready;

    modport master (
        output mem_arvalid,
        output mem_araddr,
        output mem_rready,
        input  mem_arready,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_rresp
    );

    modport slave (
        input  mem_arvalid,
        input  mem_araddr,
        input  mem_rready,
        output mem_arready,
        output mem_rvalid,
        output mem_rdata,
        output mem_rresp
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Fetch stage: one instruction in flight, REQ -> WAIT -> PRESENT -> EXEC.
// Ports: clk, rst (async active-low), bus (AR/R master), commit_valid/
// commit_pc (next PC from writeback), pc/ins/ins_fault/valid/ready
// (decode handshake), fetch_lat (REQ+WAIT cycles of the last fetch).
module ifu_fetch_ctrl #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          LAT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    ifu_fetch_ctrl_if.master bus,
    input  logic             commit_valid,
    input  logic [WIDTH-1:0] commit_pc,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      ins,
    output logic             ins_fault,
    output logic             valid,
    input  logic             ready,
    output logic [LAT_W-1:0] fetch_lat
);
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2,
        EXEC    = 2'd3
    } state_t;

    state_t     state;
    logic       arvalid;
    logic       rready;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_inc;
    logic       misaligned;

    assign cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;
    assign misaligned = (pc[1:0] != 2'b00);

    assign bus.mem_arvalid = arvalid;
    assign bus.mem_araddr  = pc;
    assign bus.mem_rready  = rready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= REQ;
            pc        <= WIDTH'(RESET_PC);
            ins       <= '0;
            ins_fault <= 1'b0;
            valid     <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            fetch_lat <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (misaligned) begin
                        arvalid   <= 1'b0;
                        ins       <= '0;
                        ins_fault <= 1'b1;
                        fetch_lat <= cnt_inc;
                        valid     <= 1'b1;
                        state     <= PRESENT;
                    end else if (!arvalid) begin
                        // First cycle out of reset: raise the request;
                        // latency is counted from the request onward.
                        arvalid <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                        if (bus.mem_arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (bus.mem_rvalid) begin
                        rready    <= 1'b0;
                        fetch_lat <= cnt_inc;
                        valid     <= 1'b1;
                        state     <= PRESENT;
                        if (bus.mem_rresp == 2'b00) begin
                            ins       <= bus.mem_rdata;
                            ins_fault <= 1'b0;
                        end else begin
                            ins       <= '0;
                            ins_fault <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (commit_valid) begin
                        pc      <= commit_pc;
                        cnt     <= '0;
                        // Request goes out on the first REQ cycle unless
                        // the new PC is misaligned.
                        arvalid <= (commit_pc[1:0] == 2'b00);
                        state   <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: reset, zero-wait fetch,
// backpressure, bus error, misaligned PC, stray events, mid-fetch reset.
module tb_ifu_fetch_ctrl;
    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ins_fault;
    logic        valid;
    logic        ready;
    logic [15:0] fetch_lat;

    int checks = 0;
    int errors = 0;
    int ar_count = 0;
    int ar_base;

    ifu_fetch_ctrl_if #(.WIDTH(32)) bus ();

    ifu_fetch_ctrl #(
        .WIDTH(32),
        .RESET_PC(32'h8000_0000),
        .LAT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .commit_valid(commit_valid),
        .commit_pc(commit_pc),
        .pc(pc),
        .ins(ins),
        .ins_fault(ins_fault),
        .valid(valid),
        .ready(ready),
        .fetch_lat(fetch_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_arvalid === 1'b1 && bus.mem_arready === 1'b1)
            ar_count <= ar_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        commit_valid = 1'b0;
        commit_pc = '0;
        ready = 1'b0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_rresp = 2'b00;
        tick();
        tick();
        checks++;
        if (bus.mem_arvalid !== 1'b0 || valid !== 1'b0 || bus.mem_rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl arvalid=%b valid=%b rready=%b want 0 0 0",
                     bus.mem_arvalid, valid, bus.mem_rready);
        end
        checks++;
        if (pc !== 32'h8000_0000 || ins !== 32'h0 || ins_fault !== 1'b0 || fetch_lat !== 16'd0) begin
            errors++;
            $display("FAIL reset_data pc=%h ins=%h flt=%b lat=%0d want 80000000 0 0 0",
                     pc, ins, ins_fault, fetch_lat);
        end
        #2 rst = 1'b1;
        tick();
        checks++;
        if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== 32'h8000_0000 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release arvalid=%b araddr=%h valid=%b want 1 80000000 0",
                     bus.mem_arvalid, bus.mem_araddr, valid);
        end
    endtask

    task automatic test_zero_wait();
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        checks++;
        if (bus.mem_rready !== 1'b1 || bus.mem_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL zw_wait rready=%b arvalid=%b want 1 0", bus.mem_rready, bus.mem_arvalid);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        bus.mem_rresp = 2'b00;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (valid !== 1'b1 || ins !== 32'h0000_0013 || ins_fault !== 1'b0 || fetch_lat !== 16'd2) begin
            errors++;
            $display("FAIL zw_present valid=%b ins=%h flt=%b lat=%0d want 1 00000013 0 2",
                     valid, ins, ins_fault, fetch_lat);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL zw_exec valid=%b want 0", valid);
        end
        commit_valid = 1'b1;
        commit_pc = 32'h8000_0004;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== 32'h8000_0004) begin
            errors++;
            $display("FAIL zw_next arvalid=%b araddr=%h want 1 80000004",
                     bus.mem_arvalid, bus.mem_araddr);
        end
    endtask

    task automatic test_backpressure();
        ar_base = ar_count;
        bus.mem_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== 32'h8000_0004) begin
                errors++;
                $display("FAIL bp_ar_stable[%0d] arvalid=%b araddr=%h want 1 80000004",
                         i, bus.mem_arvalid, bus.mem_araddr);
            end
        end
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h0010_0093;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'hffff_ffff;
        // 4 REQ cycles + 2 WAIT cycles
        checks++;
        if (fetch_lat !== 16'd6) begin
            errors++;
            $display("FAIL bp_lat lat=%0d want 6", fetch_lat);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || ins !== 32'h0010_0093 || pc !== 32'h8000_0004) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid=%b ins=%h pc=%h want 1 00100093 80000004",
                         i, valid, ins, pc);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (ar_count - ar_base !== 1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_ar ars=%0d valid=%b want 1 0", ar_count - ar_base, valid);
        end
        commit_valid = 1'b1;
        commit_pc = 32'h8000_0008;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic test_bus_error();
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hdead_beef;
        bus.mem_rresp = 2'b10;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rresp = 2'b00;
        checks++;
        if (valid !== 1'b1 || ins !== 32'h0 || ins_fault !== 1'b1 || pc !== 32'h8000_0008) begin
            errors++;
            $display("FAIL buserr valid=%b ins=%h flt=%b pc=%h want 1 00000000 1 80000008",
                     valid, ins, ins_fault, pc);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        commit_valid = 1'b1;
        commit_pc = 32'h8000_0102;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic test_misaligned();
        ar_base = ar_count;
        bus.mem_arready = 1'b1;
        checks++;
        if (bus.mem_arvalid !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_noar arvalid=%b valid=%b want 0 0", bus.mem_arvalid, valid);
        end
        tick();
        bus.mem_arready = 1'b0;
        checks++;
        if (valid !== 1'b1 || ins_fault !== 1'b1 || ins !== 32'h0 ||
            fetch_lat !== 16'd1 || pc !== 32'h8000_0102) begin
            errors++;
            $display("FAIL mis_present valid=%b flt=%b ins=%h lat=%0d pc=%h want 1 1 0 1 80000102",
                     valid, ins_fault, ins, fetch_lat, pc);
        end
        checks++;
        if (ar_count != ar_base || bus.mem_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL mis_ar_count ars=%0d arvalid=%b want 0 0",
                     ar_count - ar_base, bus.mem_arvalid);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        commit_valid = 1'b1;
        commit_pc = 32'h8000_0010;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic test_stray();
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        commit_valid = 1'b1;
        commit_pc = 32'h1234_5678;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (pc !== 32'h8000_0010 || bus.mem_rready !== 1'b1) begin
            errors++;
            $display("FAIL stray_commit_wait pc=%h rready=%b want 80000010 1", pc, bus.mem_rready);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h0000_aaaa;
        tick();
        bus.mem_rvalid = 1'b0;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (pc !== 32'h8000_0010 || valid !== 1'b1 || ins !== 32'h0000_aaaa) begin
            errors++;
            $display("FAIL stray_commit_present pc=%h valid=%b ins=%h want 80000010 1 0000aaaa",
                     pc, valid, ins);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h0000_5555;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (ins !== 32'h0000_aaaa || valid !== 1'b0 || bus.mem_rready !== 1'b0 || pc !== 32'h8000_0010) begin
            errors++;
            $display("FAIL stray_rvalid_exec ins=%h valid=%b rready=%b pc=%h want 0000aaaa 0 0 80000010",
                     ins, valid, bus.mem_rready, pc);
        end
        commit_valid = 1'b1;
        commit_pc = 32'h8000_0014;
        tick();
        commit_valid = 1'b0;
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h8000_0000 || bus.mem_rready !== 1'b0 ||
            bus.mem_arvalid !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst pc=%h rready=%b arvalid=%b valid=%b want 80000000 0 0 0",
                     pc, bus.mem_rready, bus.mem_arvalid, valid);
        end
        #1 rst = 1'b1;
        tick();
        checks++;
        if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rst_refetch arvalid=%b araddr=%h want 1 80000000",
                     bus.mem_arvalid, bus.mem_araddr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_bus_error();
        test_misaligned();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end
endmodule
